// File: rtl/act_skew_feeder_pkg.sv
// Shared sizing defaults and FSM state encoding for the activation skew feeder.
package act_skew_feeder_pkg;

    localparam int DEF_DATASIZE = 8;
    localparam int DEF_ROWS     = 4;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/act_skew_feeder_skew_delay_line.sv
// DEPTH-stage shift register of {valid, data}; one instance per lane sets that lane's skew.
module skew_delay_line #(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATASIZE-1:0] in_data,
    output logic                out_valid,
    output logic [DATASIZE-1:0] out_data
);

    logic [DEPTH-1:0]               valid_r;
    logic [DEPTH-1:0][DATASIZE-1:0] data_r;

    // Shift the {valid, data} pair one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            data_r  <= {(DEPTH*DATASIZE){1'b0}};
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Stages activation vectors into the PE rows with a per-row skew of r+1 cycles,
// tracking tile boundaries and pulsing done once the last row has emitted.
module act_skew_feeder
    import act_skew_feeder_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int ROWS     = DEF_ROWS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ROWS*DATASIZE-1:0] in_act,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [ROWS*DATASIZE-1:0] out_left_act,
    output logic [ROWS-1:0]          out_act_valid,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         beat_cnt
);

    localparam int DRAIN_W = (ROWS > 2) ? $clog2(ROWS) : 1;

    state_e             state_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [CNT_W-1:0]   beat_cnt_r;
    logic               in_ready_r;
    logic               busy_r;
    logic               done_r;
    logic               accept_s;

    assign accept_s = in_valid & in_ready_r;

    // Tile FSM: handshake, drain countdown, beat counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            drain_cnt_r <= {DRAIN_W{1'b0}};
            beat_cnt_r  <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, STREAM: begin
                    if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        busy_r     <= 1'b1;
                        if (in_last) begin
                            state_r     <= DRAIN;
                            drain_cnt_r <= DRAIN_W'(ROWS - 1);
                            in_ready_r  <= 1'b0;
                        end else begin
                            state_r <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    // done is raised one edge early so it lands on the final DRAIN cycle.
                    if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                        beat_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        drain_cnt_r <= drain_cnt_r - {{(DRAIN_W-1){1'b0}}, 1'b1};
                        if (drain_cnt_r == {{(DRAIN_W-1){1'b0}}, 1'b1}) begin
                            done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    drain_cnt_r <= {DRAIN_W{1'b0}};
                    beat_cnt_r  <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign beat_cnt = beat_cnt_r;

    // Non-accepted cycles push zero data with valid low, so bubbles stay zero on the PE side.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATASIZE-1:0] lane_data_s;

        assign lane_data_s = accept_s ? in_act[r*DATASIZE +: DATASIZE] : {DATASIZE{1'b0}};

        skew_delay_line #(
            .DATASIZE (DATASIZE),
            .DEPTH    (r + 1)
        ) u_delay (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (accept_s),
            .in_data   (lane_data_s),
            .out_valid (out_act_valid[r]),
            .out_data  (out_left_act[r*DATASIZE +: DATASIZE])
        );
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed plus randomized bench for act_skew_feeder against a time-indexed reference model.
module tb_act_skew_feeder;

    localparam int ROWS  = 4;
    localparam int DW    = 8;
    localparam int CNT_W = 16;
    localparam int HMAX  = 2048;

    logic                 clk;
    logic                 rst;
    logic [ROWS*DW-1:0]   in_act;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   out_left_act;
    logic [ROWS-1:0]      out_act_valid;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     beat_cnt;

    act_skew_feeder #(.DATASIZE(DW), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_act        (in_act),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_left_act  (out_left_act),
        .out_act_valid (out_act_valid),
        .busy          (busy),
        .done          (done),
        .beat_cnt      (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: what was accepted at each edge, plus tile timing in edge numbers.
    int               e         = 0;
    int               rst_edge  = -1;
    int               last_edge = -1000;
    bit               ready_m   = 1'b1;
    bit               busy_m    = 1'b0;
    bit               done_m    = 1'b0;
    logic [CNT_W-1:0] cnt_m     = '0;
    bit               acc_v [HMAX];
    logic [31:0]      acc_d [HMAX];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic l, input logic [31:0] d);
        logic [31:0]     exp_act;
        logic [ROWS-1:0] exp_vld;
        bit              acc;
        @(negedge clk);
        rst = r; in_valid = v; in_last = l; in_act = d;
        @(posedge clk);
        #1;
        if (r) begin
            rst_edge  = e;
            last_edge = -1000;
            cnt_m     = '0;
            busy_m    = 1'b0;
            ready_m   = 1'b1;
            done_m    = 1'b0;
            acc_v[e]  = 1'b0;
            acc_d[e]  = '0;
        end else begin
            acc      = v && ready_m;
            acc_v[e] = acc;
            acc_d[e] = d;
            if (acc) begin
                cnt_m  = cnt_m + 1'b1;
                busy_m = 1'b1;
                if (l) last_edge = e;
            end
            if (e == last_edge + ROWS) begin
                cnt_m  = '0;
                busy_m = 1'b0;
            end
            ready_m = !(e >= last_edge && e <= last_edge + ROWS - 1);
            done_m  = (e == last_edge + ROWS - 1);
        end
        exp_act = '0;
        exp_vld = '0;
        for (int k = 0; k < ROWS; k++) begin
            int idx = e - k;
            if (idx >= 0 && idx > rst_edge && acc_v[idx]) begin
                exp_vld[k]          = 1'b1;
                exp_act[k*DW +: DW] = acc_d[idx][k*DW +: DW];
            end
        end
        check("out_left_act",  64'(out_left_act),  64'(exp_act));
        check("out_act_valid", 64'(out_act_valid), 64'(exp_vld));
        check("in_ready",      64'(in_ready),      64'(ready_m));
        check("busy",          64'(busy),          64'(busy_m));
        check("done",          64'(done),          64'(done_m));
        check("beat_cnt",      64'(beat_cnt),      64'(cnt_m));
        e++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_act = '0;
        for (int i = 0; i < ROWS * 2; i++) acc_v[i] = 1'b0;

        // 1. reset
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_valid",    64'(out_act_valid), 64'd0);
        idle(1);

        // 2. single beat with last
        step(1'b0, 1'b1, 1'b1, 32'h04030201);
        check("s2_row0_c1", 64'(out_left_act[7:0]), 64'd1);
        idle(3);
        check("s2_row3_c4", 64'(out_left_act[31:24]), 64'd4);
        check("s2_done_c4", 64'(done), 64'd1);
        check("s2_cnt_c4",  64'(beat_cnt), 64'd1);
        idle(1);
        check("s2_ready_c5", 64'(in_ready), 64'd1);
        idle(1);

        // 3. back-to-back beats, last on C
        step(1'b0, 1'b1, 1'b0, 32'h0D0C0B0A);
        step(1'b0, 1'b1, 1'b0, 32'h17161514);
        step(1'b0, 1'b1, 1'b1, 32'h21201F1E);
        idle(3);
        check("s3_row3_c6", 64'(out_left_act[31:24]), 64'd33);
        check("s3_done_c6", 64'(done), 64'd1);
        check("s3_cnt_c6",  64'(beat_cnt), 64'd3);
        idle(2);

        // 4. bubble between A and B
        step(1'b0, 1'b1, 1'b0, 32'h44332211);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h88776655);
        idle(5);

        // 5. backpressure during drain
        step(1'b0, 1'b1, 1'b1, 32'h05050505);
        for (int i = 0; i < ROWS; i++) step(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
        check("s5_cnt_zero_after", 64'(beat_cnt), 64'd0);
        idle(4);

        // 6. reset mid-stream, then a fresh single-beat tile
        step(1'b0, 1'b1, 1'b0, 32'h12121212);
        step(1'b0, 1'b1, 1'b0, 32'h34343434);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s6_valid_after_rst", 64'(out_act_valid), 64'd0);
        check("s6_cnt_after_rst",   64'(beat_cnt), 64'd0);
        idle(ROWS + 1);
        step(1'b0, 1'b1, 1'b1, 32'h04030201);
        idle(4);

        // randomized traffic, including occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), $urandom);
        end
        idle(ROWS + 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
